// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline decode definitions: opcode/ALU-op encodings, instruction field
// positions and the per-instruction source-register descriptor.
package pipe_defs;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_MULT = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 22;
  localparam int RS_HI  = 21;
  localparam int RS_LO  = 17;
  localparam int RT_HI  = 16;
  localparam int RT_LO  = 12;
  localparam int ALU_HI = 6;
  localparam int ALU_LO = 2;

  localparam logic [4:0] REG_RSTATUS = 5'd30;

  // Up to three register reads per instruction; the rd slot carries r30 for bex.
  typedef struct packed {
    logic       uses_rs;
    logic       uses_rt;
    logic       uses_rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } src_info_t;

endpackage

// File: rtl/hazard_stall_ctrl_src_decode.sv
// Maps an instruction word to the set of registers it reads; shared with the
// forwarding units so both agree on what counts as a source.
module instr_src_decode
  import pipe_defs::*;
(
  input  logic [31:0] instr,
  output src_info_t   src
);

  logic [4:0] opc;
  logic       unused_bits;

  assign opc         = instr[OPC_HI:OPC_LO];
  assign unused_bits = ^{instr[11:0]};

  always_comb begin
    src.uses_rs = !(opc inside {OP_J, OP_JAL, OP_SETX, OP_BEX});
    src.uses_rt = (opc == OP_RTYPE);
    src.uses_rd = (opc inside {OP_SW, OP_BNE, OP_BLT, OP_JR, OP_BEX});
    src.rs      = instr[RS_HI:RS_LO];
    src.rt      = instr[RT_HI:RT_LO];
    src.rd      = (opc == OP_BEX) ? REG_RSTATUS : instr[RD_HI:RD_LO];
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and the
// multi-cycle mult/div handshake that freezes the front of the pipe.
module hazard_stall_ctrl
  import pipe_defs::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6,
  parameter int STAT_W     = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [31:0]       IR_Decode,
  input  logic [31:0]       IR_Execute,
  input  logic              branch_taken,
  input  logic              md_resultRDY,
  input  logic              md_exception,
  output logic              ctrl_MULT,
  output logic              ctrl_DIV,
  output logic              stall_fd,
  output logic              nop_dx,
  output logic              stall_dx,
  output logic              nop_xm,
  output logic              flush_fd,
  output logic              md_write,
  output logic              md_timeout,
  output logic              md_busy,
  output logic [STAT_W-1:0] stall_count,
  output logic [1:0]        md_state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  src_info_t         d_src;
  logic [4:0]        x_opc;
  logic [4:0]        x_rd;
  logic [4:0]        x_alu;
  logic              x_is_lw;
  logic              x_is_mult;
  logic              x_is_div;
  logic              load_use;
  logic              md_start;
  logic              full_stall;
  logic              unused_bits;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tmo_q, tmo_d;
  logic [STAT_W-1:0] stall_count_q, stall_count_d;

  instr_src_decode u_src_decode (
    .instr (IR_Decode),
    .src   (d_src)
  );

  assign x_opc       = IR_Execute[OPC_HI:OPC_LO];
  assign x_rd        = IR_Execute[RD_HI:RD_LO];
  assign x_alu       = IR_Execute[ALU_HI:ALU_LO];
  assign x_is_lw     = (x_opc == OP_LW);
  assign x_is_mult   = (x_opc == OP_RTYPE) && (x_alu == ALU_MULT);
  assign x_is_div    = (x_opc == OP_RTYPE) && (x_alu == ALU_DIV);
  assign unused_bits = ^{IR_Execute[21:7], IR_Execute[1:0]};

  // r0 is hardwired, so a load into it never creates a dependency.
  assign load_use = x_is_lw && (x_rd != 5'd0) &&
                    ((d_src.uses_rs && (d_src.rs == x_rd)) ||
                     (d_src.uses_rt && (d_src.rt == x_rd)) ||
                     (d_src.uses_rd && (d_src.rd == x_rd)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    md_start  = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((x_is_mult || x_is_div) && !branch_taken) begin
          md_start  = 1'b1;
          ctrl_MULT = x_is_mult;
          ctrl_DIV  = x_is_div;
          cnt_d     = '0;
          tmo_d     = 1'b0;
          state_d   = S_BUSY;
        end
      end
      S_BUSY: begin
        // A ready arriving on the last allowed cycle still counts as a clean result.
        if (md_resultRDY) begin
          tmo_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    full_stall = (state_q == S_BUSY) || md_start;
    stall_fd   = full_stall || (!branch_taken && load_use);
    nop_dx     = !full_stall && (branch_taken || load_use);
    flush_fd   = !full_stall && branch_taken;
    stall_dx   = full_stall;
    nop_xm     = full_stall;
    md_write   = (state_q == S_DONE);
    md_timeout = (state_q == S_DONE) && (tmo_q || md_exception);
    md_busy    = (state_q != S_IDLE);

    stall_count_d = stall_count_q;
    if (stall_fd && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      tmo_q         <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count  = stall_count_q;
  assign md_state_dbg = state_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized and directed check of hazard_stall_ctrl against a behavioural model
// built from register read-masks and an elapsed-cycle view of the mult/div op.
module tb_hazard_stall_ctrl;

  localparam int MD_TIMEOUT = 40;
  localparam int STAT_W     = 32;
  localparam int OUT_W      = 10;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [31:0]       IR_Decode, IR_Execute;
  logic              branch_taken, md_resultRDY, md_exception;
  logic              ctrl_MULT, ctrl_DIV, stall_fd, nop_dx, stall_dx, nop_xm;
  logic              flush_fd, md_write, md_timeout, md_busy;
  logic [STAT_W-1:0] stall_count;
  logic [1:0]        md_state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [OUT_W-1:0] exp_q[$];

  // model state
  bit     m_busy = 0, m_done = 0, m_tmo = 0;
  int     m_elapsed = 0;
  longint m_stalls = 0;

  hazard_stall_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(6), .STAT_W(STAT_W)) dut (
    .clock(clock), .reset_n(reset_n), .IR_Decode(IR_Decode), .IR_Execute(IR_Execute),
    .branch_taken(branch_taken), .md_resultRDY(md_resultRDY), .md_exception(md_exception),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .stall_fd(stall_fd), .nop_dx(nop_dx),
    .stall_dx(stall_dx), .nop_xm(nop_xm), .flush_fd(flush_fd), .md_write(md_write),
    .md_timeout(md_timeout), .md_busy(md_busy), .stall_count(stall_count),
    .md_state_dbg(md_state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, rd, rs, rt, alu);
    logic [4:0] f_op, f_rd, f_rs, f_rt, f_alu;
    f_op = op[4:0]; f_rd = rd[4:0]; f_rs = rs[4:0]; f_rt = rt[4:0]; f_alu = alu[4:0];
    return {f_op, f_rd, f_rs, f_rt, 5'b0, f_alu, 2'b0};
  endfunction

  // Bit n set when the instruction reads register n.
  function automatic logic [31:0] read_mask(input logic [31:0] ir);
    logic [31:0] m;
    int op;
    m  = '0;
    op = int'(ir[31:27]);
    if (!(op == 1 || op == 3 || op == 21 || op == 22)) m[ir[21:17]] = 1'b1;
    if (op == 0) m[ir[16:12]] = 1'b1;
    if (op == 7 || op == 2 || op == 6 || op == 4) m[ir[26:22]] = 1'b1;
    if (op == 22) m[30] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] rand_instr();
    int k, a, b, c;
    k = $urandom_range(0, 12);
    a = ($urandom_range(0, 7) == 0) ? 30 : $urandom_range(0, 3);
    b = $urandom_range(0, 3);
    c = $urandom_range(0, 3);
    case (k)
      0:       return mk(0, a, b, c, 0);
      1:       return mk(0, a, b, c, 6);
      2:       return mk(0, a, b, c, 7);
      3, 4:    return mk(8, a, b, 0, 0);
      5:       return mk(7, a, b, 0, 0);
      6:       return mk(1, a, b, c, 0);
      7:       return mk(3, a, b, c, 0);
      8:       return mk(4, a, b, c, 0);
      9:       return mk(2, a, b, c, 0);
      10:      return mk(6, a, b, c, 0);
      11:      return mk(21, a, b, c, 0);
      default: return mk(22, a, b, c, 0);
    endcase
  endfunction

  task automatic check_outputs();
    string names[OUT_W] = '{"md_busy", "md_timeout", "md_write", "flush_fd", "nop_xm",
                            "stall_dx", "nop_dx", "stall_fd", "ctrl_DIV", "ctrl_MULT"};
    logic [OUT_W-1:0] obs, exp;
    obs = {ctrl_MULT, ctrl_DIV, stall_fd, nop_dx, stall_dx, nop_xm, flush_fd,
           md_write, md_timeout, md_busy};
    exp = exp_q.pop_front();
    for (int i = 0; i < OUT_W; i++) check_eq(names[i], 32'(obs[i]), 32'(exp[i]));
  endtask

  // driver + model for one clock cycle
  task automatic cycle(input logic [31:0] d, input logic [31:0] x, input logic br,
                       input logic rdy, input logic exc, input logic rst_n);
    logic [31:0] mask;
    logic [4:0]  x_op, x_rd, x_alu;
    bit x_md, start, full, lu;
    bit e_sfd, e_ndx, e_flush, e_mult, e_div, e_tmo;
    @(negedge clock);
    IR_Decode = d; IR_Execute = x; branch_taken = br;
    md_resultRDY = rdy; md_exception = exc; reset_n = rst_n;
    #1;
    mask  = read_mask(d);
    x_op  = x[31:27];
    x_rd  = x[26:22];
    x_alu = x[6:2];
    x_md  = (x_op == 5'd0) && (x_alu == 5'd6 || x_alu == 5'd7);
    start = !m_busy && !m_done && x_md && !br;
    full  = m_busy || start;
    lu    = (x_op == 5'd8) && (x_rd != 5'd0) && mask[x_rd];
    e_sfd   = full || (!br && lu);
    e_ndx   = !full && (br || lu);
    e_flush = !full && br;
    e_mult  = start && (x_alu == 5'd6);
    e_div   = start && (x_alu == 5'd7);
    e_tmo   = m_done && (m_tmo || exc);
    exp_q.push_back({e_mult, e_div, e_sfd, e_ndx, full, full, e_flush,
                     m_done, e_tmo, m_busy || m_done});
    check_outputs();
    check_eq("stall_count", stall_count, 32'(m_stalls));
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_tmo = 0; m_elapsed = 0; m_stalls = 0;
    end else begin
      if (e_sfd && m_stalls < 64'hFFFF_FFFF) m_stalls++;
      if (m_done) m_done = 0;
      else if (start) begin
        m_busy = 1; m_elapsed = 0;
      end else if (m_busy) begin
        m_elapsed++;
        if (rdy) begin
          m_busy = 0; m_done = 1; m_tmo = 0;
        end else if (m_elapsed == MD_TIMEOUT) begin
          m_busy = 0; m_done = 1; m_tmo = 1;
        end
      end
    end
  endtask

  initial begin
    logic [31:0] nop, lw5, lw0, lw30, add652, add602, sw5, bex, mul, dv;
    nop    = mk(0, 0, 0, 0, 0);
    lw5    = mk(8, 5, 1, 0, 0);
    lw0    = mk(8, 0, 1, 0, 0);
    lw30   = mk(8, 30, 1, 0, 0);
    add652 = mk(0, 6, 5, 2, 0);
    add602 = mk(0, 6, 0, 2, 0);
    sw5    = mk(7, 5, 1, 0, 0);
    bex    = mk(22, 0, 0, 0, 0);
    mul    = mk(0, 7, 1, 2, 6);
    dv     = mk(0, 7, 1, 2, 7);

    reset_n = 1'b0; IR_Decode = nop; IR_Execute = nop;
    branch_taken = 0; md_resultRDY = 0; md_exception = 0;
    repeat (2) @(posedge clock);

    cycle(nop, nop, 0, 0, 0, 0);
    cycle(nop, nop, 0, 0, 0, 1);
    // load-use on rs, then the bubble clears it
    cycle(add652, lw5, 0, 0, 0, 1);
    cycle(add652, nop, 0, 0, 0, 1);
    cycle(add602, lw0, 0, 0, 0, 1);
    cycle(sw5, lw5, 0, 0, 0, 1);
    cycle(sw5, nop, 0, 0, 0, 1);
    cycle(bex, lw30, 0, 0, 0, 1);
    cycle(bex, nop, 0, 0, 0, 1);
    // branch beats load-use
    cycle(add652, lw5, 1, 0, 0, 1);
    // mult with ready 17 cycles after start
    cycle(nop, mul, 0, 0, 0, 1);
    for (int i = 1; i <= 17; i++) cycle(nop, mul, 0, i == 17, 0, 1);
    cycle(nop, mul, 0, 0, 0, 1);
    cycle(nop, nop, 0, 0, 0, 1);
    // div that never completes
    cycle(nop, dv, 0, 0, 0, 1);
    for (int i = 0; i < MD_TIMEOUT; i++) cycle(nop, dv, 0, 0, 0, 1);
    cycle(nop, dv, 0, 0, 0, 1);
    cycle(nop, nop, 0, 0, 0, 1);
    // reset on the 5th BUSY cycle
    cycle(nop, mul, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(nop, mul, 0, 0, 0, 1);
    cycle(nop, mul, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(nop, nop, 0, 0, 0, 1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(rand_instr(), rand_instr(), $urandom_range(0, 7) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 199) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Hazard and stall controller for the 5-stage pipeline. It is the counterpart to operand forwarding: where forwarding cannot supply a value, this block stalls, bubbles or flushes. It covers three cases:
- load-use hazards between Decode and Execute;
- the multi-cycle mult/div handshake in Execute;
- taken-branch/jump flushes.
Outputs drive the PC enable, the F/D, D/X and X/M latch enables, and the NOP-insert muxes.

Parameters:
MD_TIMEOUT, 40, max cycles in BUSY before mult/div is forced complete with exception
CNT_W, 6, width of mult/div cycle counter (must hold MD_TIMEOUT)
STAT_W, 32, width of saturating stall-cycle statistics counter

Ports:
clock  in  1  pipeline clock
reset_n  in  1  synchronous, active-low reset
IR_Decode  in  32  instruction in F/D latch
IR_Execute  in  32  instruction in D/X latch
branch_taken  in  1  Execute resolved taken branch/jump (j, jal, jr, bne, blt, bex)
md_resultRDY  in  1  mult/div unit result ready
md_exception  in  1  mult/div unit exception flag
ctrl_MULT  out  1  one-cycle start pulse to mult/div
ctrl_DIV  out  1  one-cycle start pulse to mult/div
stall_fd  out  1  hold PC and F/D latch
nop_dx  out  1  load NOP into D/X
stall_dx  out  1  hold D/X latch
nop_xm  out  1  load NOP into X/M
flush_fd  out  1  load NOP into F/D
md_write  out  1  X/M latch takes mult/div result this cycle
md_timeout  out  1  mult/div forced complete; write 1 or 2 to r30 (rstatus)
md_busy  out  1  FSM not IDLE
stall_count  out  STAT_W  saturating count of cycles with stall_fd=1

Behaviour:
Decode fields (common):
- opcode [31:27], rd [26:22], rs [21:17], rt [16:12], ALU op [6:2].
- R-type opcode 00000; mult ALU op 00110; div ALU op 00111; lw opcode 01000.

Decode source set:
- rs: all except j (00001), jal (00011), setx (10101), bex (10110).
- rt: R-type only.
- rd: sw (00111), bne (00010), blt (00110), jr (00100).
- bex reads r30.

Load-use hazard (combinational):
- Condition: IR_Execute is lw, rd≠0, and rd matches any Decode source.
- Response: stall_fd=1 and nop_dx=1 for exactly one cycle. The next cycle the lw is in Memory and forwarding covers the operand.

Branch flush (combinational):
- When branch_taken=1: flush_fd=1, nop_dx=1, stall_fd=0.
- Load-use stall is suppressed that cycle.

Mult/div FSM, states IDLE, BUSY, DONE:
- IDLE:
  - If IR_Execute is mult/div and branch_taken=0: ctrl_MULT or ctrl_DIV=1 (combinational, this cycle only), assert full stall (stall_fd, stall_dx, nop_xm), counter←0, next state BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Full stall asserted, counter increments.
  - md_resultRDY=1 → DONE.
  - Counter reaches MD_TIMEOUT-1 without ready → DONE with timeout flag registered.
- DONE (one cycle):
  - Stalls released, md_write=1, md_timeout = (timeout flag | md_exception).
  - Next state IDLE. The mult/div instruction leaves D/X at this edge, so no retrigger occurs.
- md_resultRDY while in IDLE is ignored.
- md_busy=1 in BUSY and DONE.

Priority:
1. mult/div full stall (BUSY, or IDLE start cycle).
2. branch flush.
3. load-use.
- A branch cannot be taken while a mult/div instruction is in Execute.

stall_count:
- Increments on every cycle with stall_fd=1.
- Saturates at all-ones.

Reset (clocked, reset_n=0):
- State IDLE, counter 0, timeout flag 0, stall_count 0.
- All outputs read 0 in the cycle after reset, given non-hazard IR inputs.
- Reset mid-BUSY aborts the operation; no ctrl pulse, md_write or md_timeout follows.

Decomposition:
- Shared package pipe_defs: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_J, OP_JAL, OP_JR, OP_BNE, OP_BLT, OP_SETX, OP_BEX), ALU op constants (ALU_MULT, ALU_DIV), field bit ranges, REG_RSTATUS=30.
- One sub-module, instr_src_decode: maps an instruction to {uses_rs, uses_rt, uses_rd, src regs}. Reusable by the forwarding units.
- FSM and counters stay in the top-level module.

Test Plan:
- lw r5 in X, add r6,r5,r2 in D → stall_fd=1, nop_dx=1 for exactly 1 cycle, then 0; stall_count=1.
- lw r0 in X, add r6,r0,r2 in D → no stall; sw r5 in D behind lw r5 → stall (rd source).
- mult in X, md_resultRDY asserted 17 cycles after start → ctrl_MULT high 1 cycle; stall 18 cycles; DONE cycle md_write=1, md_timeout=0; ctrl_MULT never re-pulses.
- div in X, md_resultRDY never asserted → DONE after MD_TIMEOUT=40 BUSY cycles with md_timeout=1, md_write=1.
- branch_taken=1 with lw r5 in X and D using r5 → flush_fd=1, nop_dx=1, stall_fd=0.
- reset_n=0 on 5th BUSY cycle → next cycle md_busy=0, all stall outputs 0, no md_write afterwards.
